lif_step_controller: RTL and testbench

Sequential front end for the combinational `neuron` datapath. It holds the neuron's configuration registers: weights, decay shift and negative threshold. It also holds the state carried between timesteps: membrane potential and last spike. Each timestep is triggered by a write of the input spike vector. The block feeds all of these to the neuron, captures `u_out`/`is_spike` one evaluation cycle later, and keeps a saturating spike count. It sits directly upstream of the neuron and closes its feedback loop.

---
 rtl/lif_pkg.sv | 18 +
 rtl/lif_step_controller_sat_counter.sv | 23 ++
 rtl/lif_step_controller.sv | 94 +++++++++
 tb/tb_lif_step_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron step controller.
// Register address map, FSM states and counter limit.
package lif_pkg;

  localparam logic [2:0] ADDR_W      = 3'd0;
  localparam logic [2:0] ADDR_SHIFT  = 3'd1;
  localparam logic [2:0] ADDR_TETA   = 3'd2;
  localparam logic [2:0] ADDR_X_STEP = 3'd3;
  localparam logic [2:0] ADDR_CLEAR  = 3'd4;

  localparam logic [7:0] COUNT_MAX = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

endpackage

// File: rtl/lif_step_controller_sat_counter.sv
// 8-bit saturating event counter.
// Synchronous clear wins over increment.
module sat_counter
  import lif_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/lif_step_controller.sv
// Register front end and timestep sequencer for the LIF neuron.
// Closes the potential/spike feedback loop around the neuron.
module lif_step_controller
  import lif_pkg::*;
#(
  parameter int N_STAGE = 2,
  localparam int N  = 2 ** N_STAGE,
  localparam int UW = N_STAGE + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic [N-1:0]  w,
  output logic [N-1:0]  x,
  output logic [2:0]    shift,
  output logic [UW-1:0] minus_teta,
  output logic [UW-1:0] previus_u,
  output logic          was_spike,
  input  logic [UW-1:0] u_out,
  input  logic          is_spike,
  output logic          step_valid,
  output logic          spike_out,
  output logic [7:0]    spike_count
);

  state_t state;
  logic   accept;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   unused_wr_data;

  assign unused_wr_data = ^wr_data;

  assign wr_ready  = (state == IDLE);
  assign accept    = wr_en && wr_ready;
  assign spike_out = was_spike;
  assign cnt_clr   = accept && (wr_addr == ADDR_CLEAR);
  assign cnt_inc   = (state == EVAL) && is_spike;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      w          <= '0;
      x          <= '0;
      shift      <= '0;
      minus_teta <= '0;
      previus_u  <= '0;
      was_spike  <= 1'b0;
      step_valid <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            case (wr_addr)
              ADDR_W:     w          <= wr_data[N-1:0];
              ADDR_SHIFT: shift      <= wr_data[2:0];
              ADDR_TETA:  minus_teta <= wr_data[UW-1:0];
              ADDR_X_STEP: begin
                x     <= wr_data[N-1:0];
                state <= EVAL;
              end
              ADDR_CLEAR: begin
                previus_u <= '0;
                was_spike <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        EVAL: begin
          // neuron inputs were stable all cycle; commit its result
          previus_u  <= u_out;
          was_spike  <= is_spike;
          step_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (spike_count)
  );

endmodule

// File: tb/tb_lif_step_controller.sv
// Directed bench for lif_step_controller, N_STAGE=2.
// The bench plays the neuron by driving u_out/is_spike directly.
module tb_lif_step_controller;

  localparam int N  = 4;
  localparam int UW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic [N-1:0]  w;
  logic [N-1:0]  x;
  logic [2:0]    shift;
  logic [UW-1:0] minus_teta;
  logic [UW-1:0] previus_u;
  logic          was_spike;
  logic [UW-1:0] u_out;
  logic          is_spike;
  logic          step_valid;
  logic          spike_out;
  logic [7:0]    spike_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lif_step_controller #(.N_STAGE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .w           (w),
    .x           (x),
    .shift       (shift),
    .minus_teta  (minus_teta),
    .previus_u   (previus_u),
    .was_spike   (was_spike),
    .u_out       (u_out),
    .is_spike    (is_spike),
    .step_valid  (step_valid),
    .spike_out   (spike_out),
    .spike_count (spike_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive at negedge, sampled at next posedge, returns 1 after it
  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_step(input logic [7:0] d);
    do_write(3'd3, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    u_out    = '0;
    is_spike = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", wr_ready, 1);
    check("rst_w", w, 0);
    check("rst_x", x, 0);
    check("rst_valid", step_valid, 0);
    check("rst_count", spike_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_write(3'd0, 8'hAB);
    check("cfg_w", w, 4'hB);
    do_write(3'd1, 8'h05);
    check("cfg_shift", shift, 5);
    do_write(3'd2, 8'hFC);
    check("cfg_teta", minus_teta, 4'hC);

    // single step with a write dropped during EVAL
    u_out    = 4'h6;
    is_spike = 1'b1;
    do_write(3'd3, 8'h03);
    check("step_x", x, 3);
    check("eval_ready", wr_ready, 0);
    check("eval_valid", step_valid, 0);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 3'd0;
    wr_data = 8'h0F;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("cmt_valid", step_valid, 1);
    check("cmt_ready", wr_ready, 1);
    check("cmt_u", previus_u, 6);
    check("cmt_spike", was_spike, 1);
    check("cmt_sout", spike_out, 1);
    check("cmt_count", spike_count, 1);
    check("drop_w", w, 4'hB);
    @(posedge clk);
    #1;
    check("pulse_end", step_valid, 0);
    check("no_extra", spike_count, 1);

    for (int i = 0; i < 99; i++) do_step(8'h01);
    check("count_100", spike_count, 100);
    for (int i = 0; i < 160; i++) do_step(8'h01);
    check("sat_255", spike_count, 255);

    u_out    = 4'h9;
    is_spike = 1'b0;
    do_step(8'h01);
    check("ns_u", previus_u, 9);
    check("ns_spike", was_spike, 0);
    check("ns_count", spike_count, 255);

    do_write(3'd5, 8'hFF);
    check("nop_w", w, 4'hB);
    check("nop_teta", minus_teta, 4'hC);

    do_write(3'd4, 8'h00);
    check("clr_u", previus_u, 0);
    check("clr_spike", was_spike, 0);
    check("clr_count", spike_count, 0);
    check("clr_w", w, 4'hB);
    check("clr_shift", shift, 5);
    check("clr_teta", minus_teta, 4'hC);
    check("clr_x", x, 1);

    // reset in EVAL aborts the step
    u_out    = 4'h3;
    is_spike = 1'b1;
    do_write(3'd3, 8'h02);
    check("ab_ready0", wr_ready, 0);
    rst_n = 1'b0;
    #1;
    check("ab_ready", wr_ready, 1);
    check("ab_x", x, 0);
    @(posedge clk);
    #1;
    check("ab_valid", step_valid, 0);
    check("ab_u", previus_u, 0);
    check("ab_count", spike_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ab_valid2", step_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
